// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
//   Shared definitions for the RV32I decode stage:
//     - major opcode constants (instr[6:0])
//     - opcode class codes (O_EX_OPCLASS encoding) and their width
//     - immediate format selector plus the immediate builder
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int OPCLASS_W = 4;

    typedef enum logic [OPCLASS_W-1:0] {
        CLS_OP     = 4'd0,
        CLS_OP_IMM = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8,
        CLS_FENCE  = 4'd9,
        CLS_SYSTEM = 4'd10
    } opclass_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Build the sign-extended immediate; instr[31] is the sign bit of every form.
    function automatic logic [31:0] gen_imm(imm_fmt_e fmt, logic [31:0] instr);
        logic [31:0] imm;
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// ---------------------------------------------------------------------------
// rv32i_decoder
//   Purely combinational RV32I instruction classifier.
//   Ports:
//     instr     in  32  instruction word
//     opclass   out 4   opcode class code (0 for illegal)
//     imm       out 32  sign-extended immediate (0 for formats without one)
//     rd_wen    out 1   instruction writes rd and rd != 0
//     uses_rs1  out 1   instruction reads rs1
//     uses_rs2  out 1   instruction reads rs2
//     illegal   out 1   unknown opcode or instr[1:0] != 2'b11
// ---------------------------------------------------------------------------
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic [31:0]          instr,
    output logic [OPCLASS_W-1:0] opclass,
    output logic [31:0]          imm,
    output logic                 rd_wen,
    output logic                 uses_rs1,
    output logic                 uses_rs2,
    output logic                 illegal
);

    opclass_e cls;
    imm_fmt_e fmt;
    logic     writes_rd;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        cls       = CLS_OP;
        fmt       = IMM_NONE;
        writes_rd = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        illegal   = 1'b0;
        // The full 7-bit match also rejects compressed encodings, since every
        // listed opcode ends in 2'b11.
        case (instr[6:0])
            OPC_OP:     begin cls = CLS_OP;     writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_OP_IMM: begin cls = CLS_OP_IMM; fmt = IMM_I; writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OPC_LOAD:   begin cls = CLS_LOAD;   fmt = IMM_I; writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OPC_STORE:  begin cls = CLS_STORE;  fmt = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_BRANCH: begin cls = CLS_BRANCH; fmt = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_JAL:    begin cls = CLS_JAL;    fmt = IMM_J; writes_rd = 1'b1; end
            OPC_JALR:   begin cls = CLS_JALR;   fmt = IMM_I; writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OPC_LUI:    begin cls = CLS_LUI;    fmt = IMM_U; writes_rd = 1'b1; end
            OPC_AUIPC:  begin cls = CLS_AUIPC;  fmt = IMM_U; writes_rd = 1'b1; end
            OPC_FENCE:  begin cls = CLS_FENCE;  fmt = IMM_I; end
            OPC_SYSTEM: begin cls = CLS_SYSTEM; fmt = IMM_I; end
            default:    illegal = 1'b1;
        endcase
    end

    assign opclass = cls;
    assign imm     = gen_imm(fmt, instr);
    assign rd_wen  = writes_rd && (instr[11:7] != 5'd0);

endmodule

// File: rtl/rv32i_id_stage.sv
// ---------------------------------------------------------------------------
// rv32i_id_stage
//   RV32I instruction-decode / operand-fetch stage.
//   Ports:
//     I_CLK, I_RSTN                  clock (rising edge), async active-low reset
//     I_FLUSH                        redirect from EX; kills ID and ID/EX
//     I_IF_VALID/I_IF_INSTR/I_IF_PC  fetch side, O_IF_READY back to fetch
//     O_RF_SRC*_ADDR, I_RF_SRC*_DATA combinational GPR read ports
//     I_WB_*                         write-back port, bypassed into operands
//     O_EX_*, I_EX_READY             ID/EX pipeline register towards execute
//   Parameters:
//     BYPASS_EN      forward same-cycle write-back data to the operands
//     LOAD_USE_STALL insert one bubble on a load-use hazard
// ---------------------------------------------------------------------------
module rv32i_id_stage
    import rv32i_pkg::*;
#(
    parameter bit BYPASS_EN      = 1'b1,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic                 I_CLK,
    input  logic                 I_RSTN,
    input  logic                 I_FLUSH,
    input  logic                 I_IF_VALID,
    input  logic [31:0]          I_IF_INSTR,
    input  logic [31:0]          I_IF_PC,
    output logic                 O_IF_READY,
    output logic [4:0]           O_RF_SRC1_ADDR,
    output logic [4:0]           O_RF_SRC2_ADDR,
    input  logic [31:0]          I_RF_SRC1_DATA,
    input  logic [31:0]          I_RF_SRC2_DATA,
    input  logic                 I_WB_WR_EN,
    input  logic [4:0]           I_WB_DST_ADDR,
    input  logic [31:0]          I_WB_DST_DATA,
    output logic                 O_EX_VALID,
    input  logic                 I_EX_READY,
    output logic [31:0]          O_EX_PC,
    output logic [31:0]          O_EX_RS1_DATA,
    output logic [31:0]          O_EX_RS2_DATA,
    output logic [4:0]           O_EX_RS1_ADDR,
    output logic [4:0]           O_EX_RS2_ADDR,
    output logic [31:0]          O_EX_IMM,
    output logic [4:0]           O_EX_RD_ADDR,
    output logic                 O_EX_RD_WEN,
    output logic [OPCLASS_W-1:0] O_EX_OPCLASS,
    output logic [2:0]           O_EX_FUNCT3,
    output logic                 O_EX_FUNCT7B5,
    output logic                 O_EX_ILLEGAL
);

    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [OPCLASS_W-1:0] dec_opclass;
    logic [31:0]          dec_imm;
    logic                 dec_rd_wen;
    logic                 dec_uses_rs1;
    logic                 dec_uses_rs2;
    logic                 dec_illegal;
    logic                 adv;
    logic                 load_in_ex;
    logic                 hz;
    logic [31:0]          op1;
    logic [31:0]          op2;

    assign rs1            = I_IF_INSTR[19:15];
    assign rs2            = I_IF_INSTR[24:20];
    assign O_RF_SRC1_ADDR = rs1;
    assign O_RF_SRC2_ADDR = rs2;

    rv32i_decoder u_decoder (
        .instr    (I_IF_INSTR),
        .opclass  (dec_opclass),
        .imm      (dec_imm),
        .rd_wen   (dec_rd_wen),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .illegal  (dec_illegal)
    );

    // A load still in ID/EX has no data yet; a dependent instruction in ID
    // must wait one cycle so EX-stage forwarding can pick the load result up.
    assign adv        = !O_EX_VALID || I_EX_READY;
    assign load_in_ex = O_EX_VALID && (O_EX_OPCLASS == CLS_LOAD) && (O_EX_RD_ADDR != 5'd0);
    assign hz         = LOAD_USE_STALL && load_in_ex &&
                        ((dec_uses_rs1 && (O_EX_RD_ADDR == rs1)) ||
                         (dec_uses_rs2 && (O_EX_RD_ADDR == rs2)));
    assign O_IF_READY = adv && !hz && !I_FLUSH;

    // The GPR file only updates on the clock edge, so a write-back landing in
    // the same cycle must be taken from the write-back bus. x0 is always zero.
    always_comb begin
        op1 = I_RF_SRC1_DATA;
        op2 = I_RF_SRC2_DATA;
        if (BYPASS_EN && I_WB_WR_EN && (I_WB_DST_ADDR == rs1)) op1 = I_WB_DST_DATA;
        if (BYPASS_EN && I_WB_WR_EN && (I_WB_DST_ADDR == rs2)) op2 = I_WB_DST_DATA;
        if (rs1 == 5'd0) op1 = '0;
        if (rs2 == 5'd0) op2 = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            O_EX_VALID <= 1'b0;
        end else if (I_FLUSH) begin
            O_EX_VALID <= 1'b0;
        end else if (adv && hz) begin
            O_EX_VALID <= 1'b0;
        end else if (adv) begin
            O_EX_VALID <= I_IF_VALID;
        end
    end

    // NOTE: the payload is reset too, because the execute stage observes these
    // outputs directly and they must read as zero out of reset.
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            O_EX_PC       <= '0;
            O_EX_RS1_DATA <= '0;
            O_EX_RS2_DATA <= '0;
            O_EX_RS1_ADDR <= '0;
            O_EX_RS2_ADDR <= '0;
            O_EX_IMM      <= '0;
            O_EX_RD_ADDR  <= '0;
            O_EX_RD_WEN   <= 1'b0;
            O_EX_OPCLASS  <= '0;
            O_EX_FUNCT3   <= '0;
            O_EX_FUNCT7B5 <= 1'b0;
            O_EX_ILLEGAL  <= 1'b0;
        end else if (adv && !hz && !I_FLUSH) begin
            // Payload is don't-care for flushes and bubbles, so it only moves
            // when a real instruction slot is taken.
            O_EX_PC       <= I_IF_PC;
            O_EX_RS1_DATA <= op1;
            O_EX_RS2_DATA <= op2;
            O_EX_RS1_ADDR <= rs1;
            O_EX_RS2_ADDR <= rs2;
            O_EX_IMM      <= dec_imm;
            O_EX_RD_ADDR  <= I_IF_INSTR[11:7];
            O_EX_RD_WEN   <= dec_rd_wen && !dec_illegal;
            O_EX_OPCLASS  <= dec_illegal ? OPCLASS_W'(CLS_OP) : dec_opclass;
            O_EX_FUNCT3   <= I_IF_INSTR[14:12];
            O_EX_FUNCT7B5 <= I_IF_INSTR[30];
            O_EX_ILLEGAL  <= dec_illegal;
        end
    end

endmodule

// File: doc/rv32i_id_stage.md
Name: rv32i_id_stage

Overview:
Instruction-decode / operand-fetch stage of the RV32I pipeline.
- Accepts one instruction per cycle from fetch via a valid/ready handshake.
- Drives the GPR file's two combinational read addresses and merges write-back bypass data.
- Generates the immediate, classifies the opcode and detects load-use hazards.
- Holds the result in an ID/EX pipeline register consumed by the execute stage.

Parameters:
- BYPASS_EN, 1: 1 = forward same-cycle write-back data to the operands; 0 = read GPR data only.
- LOAD_USE_STALL, 1: 1 = insert one bubble on a load-use hazard; 0 = no hazard stall.

Ports:
- I_CLK  in  1  clock, rising edge.
- I_RSTN  in  1  reset, asynchronous, active-low.
- I_FLUSH  in  1  redirect from EX (taken branch/jump); kills ID and ID/EX contents.
- I_IF_VALID  in  1  fetch has an instruction.
- I_IF_INSTR  in  32  instruction word.
- I_IF_PC  in  32  PC of I_IF_INSTR.
- O_IF_READY  out  1  ID accepts the instruction this cycle.
- O_RF_SRC1_ADDR  out  5  I_IF_INSTR[19:15], combinational.
- O_RF_SRC2_ADDR  out  5  I_IF_INSTR[24:20], combinational.
- I_RF_SRC1_DATA  in  32  GPR read data 1.
- I_RF_SRC2_DATA  in  32  GPR read data 2.
- I_WB_WR_EN  in  1  write-back write enable; same signal drives the GPR write port.
- I_WB_DST_ADDR  in  5  write-back destination.
- I_WB_DST_DATA  in  32  write-back data.
- O_EX_VALID  out  1  ID/EX holds a valid instruction.
- I_EX_READY  in  1  EX consumes ID/EX this cycle.
- O_EX_PC  out  32  PC.
- O_EX_RS1_DATA  out  32  operand 1.
- O_EX_RS2_DATA  out  32  operand 2.
- O_EX_RS1_ADDR  out  5  rs1 index, for EX forwarding.
- O_EX_RS2_ADDR  out  5  rs2 index, for EX forwarding.
- O_EX_IMM  out  32  sign-extended immediate.
- O_EX_RD_ADDR  out  5  destination register.
- O_EX_RD_WEN  out  1  instruction writes rd, and rd≠0.
- O_EX_OPCLASS  out  4  opcode class code.
- O_EX_FUNCT3  out  3  instr[14:12].
- O_EX_FUNCT7B5  out  1  instr[30].
- O_EX_ILLEGAL  out  1  unknown opcode, or instr[1:0]≠2'b11.

Behaviour:
- Reset (I_RSTN=0, asynchronous): all O_EX_* outputs are 0. O_IF_READY follows its equation.
- Advance condition: adv = !O_EX_VALID || I_EX_READY.
- Load-use hazard. hz = LOAD_USE_STALL && O_EX_VALID && O_EX_OPCLASS==LOAD && O_EX_RD_ADDR≠0, and O_EX_RD_ADDR equals either:
  - rs1, when the decoded class uses rs1 (JALR, BRANCH, LOAD, STORE, OP_IMM, OP), or
  - rs2, when the decoded class uses rs2 (BRANCH, STORE, OP).
- O_IF_READY = adv && !hz && !I_FLUSH. This is combinational; there is no internal skid buffer.
- ID/EX update on each rising edge, in priority order:
  1. I_FLUSH: O_EX_VALID←0; the payload is don't-care.
  2. adv && hz: insert a bubble, O_EX_VALID←0. Fetch holds its instruction.
  3. adv: O_EX_VALID←I_IF_VALID, and the payload loads from decode.
  4. Otherwise: hold all ID/EX outputs unchanged.
- Latency: one cycle from an accepted fetch to O_EX_VALID. Full throughput of 1 instruction/cycle when there is no hazard.
- Operand select, per source, when BYPASS_EN, I_WB_WR_EN, I_WB_DST_ADDR==rsN and rsN≠0: the operand takes I_WB_DST_DATA; otherwise it takes I_RF_SRCN_DATA.
  - The bypass is required because the GPR file writes on the edge.
  - Address 0 always yields 0 regardless of bypass.
- Forwarding from EX and MEM is not done here. After a load-use bubble, the load's data reaches EX through EX-stage forwarding.
- Immediates, sign bit instr[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - FENCE and SYSTEM use the I form.
- OPCLASS codes, with the opcode that selects each:
  - 0 OP (0110011)
  - 1 OP_IMM (0010011)
  - 2 LOAD (0000011)
  - 3 STORE (0100011)
  - 4 BRANCH (1100011)
  - 5 JAL (1101111)
  - 6 JALR (1100111)
  - 7 LUI (0110111)
  - 8 AUIPC (0010111)
  - 9 FENCE (0001111)
  - 10 SYSTEM (1110011)
- Illegal instruction: OPCLASS=0, O_EX_ILLEGAL=1, O_EX_RD_WEN=0, and the instruction is still passed as valid.
- O_EX_RD_WEN=1 for OP, OP_IMM, LOAD, JAL, JALR, LUI and AUIPC, only when rd≠0.
- Reset deasserted mid-stall: the stage restarts empty, and no stale hazard is seen.

Decomposition:
- Shared package rv32i_pkg holds:
  - the opcode constants;
  - the OPCLASS codes and width;
  - the immediate-format enum.
- One combinational sub-module, rv32i_decoder: instruction in; class, immediate, rd_wen, uses_rs1, uses_rs2 and illegal out.
- Hazard logic, bypass and the ID/EX register stay in the top level.

Test Plan:
1. Decode and immediate: addi x5,x0,-1 (0xFFF00293) → OPCLASS=1, IMM=0xFFFFFFFF, RD=5, RD_WEN=1, one cycle later.
2. Bypass: WB writes x3=0x12345678 in the same cycle that `add x4,x3,x3` is in ID, while the RF returns 0 → RS1_DATA=RS2_DATA=0x12345678. Same stimulus with WB dst x0 → operands 0.
3. Load-use hazard: `lw x6,0(x1)` followed by `add x7,x6,x2` → O_IF_READY=0 for one cycle, one bubble (VALID=0), then the add issues. The same sequence with `lui x6` first → no stall.
4. Backpressure: I_EX_READY=0 for 3 cycles → ID/EX is held stable and O_IF_READY=0. On release, instructions resume with none lost and none duplicated.
5. Flush: I_FLUSH during a stall and during a valid issue → next-cycle O_EX_VALID=0, and the held instruction is dropped.
6. Illegal: 0x00000000 → VALID=1, ILLEGAL=1, RD_WEN=0. Asynchronous reset asserted mid-stream → outputs 0 immediately.
